// File: rtl/frog_input_conditioner.sv
// Button front end for the frog game: synchronizes and debounces four active-low buttons
// and issues one prioritized step per press over valid/ready. Define AUTO_REPEAT_EN for hold-to-repeat.
module frog_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       move_r,
  input  logic       move_l,
  input  logic       move_u,
  input  logic       move_d,
  input  logic       step_ready,
  output logic       step_valid,
  output logic [1:0] step_dir,
  output logic       any_pressed,
  output logic       repeat_active
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_ONE = DW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    HOLD  = 2'b10
  } state_e;

  // Bit index equals the step_dir code: 0 right, 1 left, 2 down, 3 up.
  logic [3:0]    raw_s;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d;
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];
  logic [3:0]    pressed_s;
  logic [1:0]    prio_dir_s;

  state_e     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic       any_pressed_q;

  assign raw_s     = {move_u, move_d, move_l, move_r};
  assign pressed_s = ~stable_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if ((db_cnt_q[i] + DB_ONE) == DB_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 4'b1111;
      sync2_q  <= 4'b1111;
      stable_q <= 4'b1111;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= raw_s;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  always_comb begin
    if (pressed_s[0]) begin
      prio_dir_s = 2'b00;
    end else if (pressed_s[1]) begin
      prio_dir_s = 2'b01;
    end else if (pressed_s[2]) begin
      prio_dir_s = 2'b10;
    end else if (pressed_s[3]) begin
      prio_dir_s = 2'b11;
    end else begin
      prio_dir_s = 2'b00;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = ($clog2(RMAX) < 1) ? 1 : $clog2(RMAX);
  localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LOAD = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] R_ONE   = RW'(1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_act_q, rpt_act_d;

  assign repeat_active = rpt_act_q;
`else
  assign repeat_active = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
`ifdef AUTO_REPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
    rpt_act_d = rpt_act_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef AUTO_REPEAT_EN
        rpt_act_d = 1'b0;
`endif
        if (|pressed_s) begin
          dir_d   = prio_dir_s;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (step_ready) begin
          state_d = HOLD;
`ifdef AUTO_REPEAT_EN
          rpt_cnt_d = rpt_act_q ? RP_LOAD : RD_LOAD;
`endif
        end else begin
          state_d = ISSUE;
        end
      end
      HOLD: begin
        // Only the latched button matters here; others wait for IDLE.
        if (!pressed_s[dir_q]) begin
          state_d = IDLE;
`ifdef AUTO_REPEAT_EN
          rpt_act_d = 1'b0;
        end else if (rpt_cnt_q == '0) begin
          state_d   = ISSUE;
          rpt_act_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q - R_ONE;
`else
        end else begin
          state_d = HOLD;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      dir_q         <= 2'b00;
      any_pressed_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q     <= '0;
      rpt_act_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      any_pressed_q <= |pressed_s;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_act_q     <= rpt_act_d;
`endif
    end
  end

  assign step_valid  = (state_q == ISSUE);
  assign step_dir    = dir_q;
  assign any_pressed = any_pressed_q;

endmodule
